chrono_ctrl: RTL and testbench

CHRONO_CTRL -- requirements
Module: chrono_ctrl

---
 rtl/chrono_pkg.sv | 80 ++++++++
 rtl/chrono_if.sv | 22 ++
 rtl/chrono_tick.sv | 26 ++
 rtl/chrono_ctrl.sv | 123 ++++++++++++
 tb/tb_chrono_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chrono_pkg.sv
// chrono_pkg: shared types and constants for the chrono_ctrl stopwatch.
// The LAP state only exists when CHRONO_LAP_EN is defined.
package chrono_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
`ifdef CHRONO_LAP_EN
      ,LAP  = 2'd3
`endif
   } state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t min_t;
      bcd_t min_u;
      bcd_t sec_t;
      bcd_t sec_u;
      bcd_t cs_t;
      bcd_t cs_u;
   } disp_t;

   localparam int unsigned CS_MAX  = 99;
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;

   // Increment a tens/units BCD pair that wraps after max_val.
   // Returns {tens, units, carry_out}.
   function automatic logic [8:0] pair_inc(input bcd_t t, input bcd_t u,
                                           input int unsigned max_val);
      bcd_t tn;
      bcd_t un;
      logic co;
      tn = t;
      un = u;
      co = 1'b0;
      if (t == 4'(max_val / 10) && u == 4'(max_val % 10)) begin
         tn = '0;
         un = '0;
         co = 1'b1;
      end else if (u == 4'd9) begin
         un = '0;
         tn = t + 4'd1;
      end else begin
         un = u + 4'd1;
      end
      return {tn, un, co};
   endfunction

   // One centisecond later, with cs -> sec -> min carries.
   function automatic disp_t bcd_inc(input disp_t c);
      disp_t      n;
      logic [8:0] r;
      n = c;
      r = pair_inc(c.cs_t, c.cs_u, CS_MAX);
      n.cs_t = r[8:5];
      n.cs_u = r[4:1];
      if (r[0]) begin
         r = pair_inc(c.sec_t, c.sec_u, SEC_MAX);
         n.sec_t = r[8:5];
         n.sec_u = r[4:1];
         if (r[0]) begin
            r = pair_inc(c.min_t, c.min_u, MIN_MAX);
            n.min_t = r[8:5];
            n.min_u = r[4:1];
         end
      end
      return n;
   endfunction

   // True when the count sits at its ceiling 59:59.99.
   function automatic logic is_full(input disp_t c);
      return c.min_t == 4'(MIN_MAX / 10) && c.min_u == 4'(MIN_MAX % 10) &&
             c.sec_t == 4'(SEC_MAX / 10) && c.sec_u == 4'(SEC_MAX % 10) &&
             c.cs_t  == 4'(CS_MAX / 10)  && c.cs_u  == 4'(CS_MAX % 10);
   endfunction

endpackage

// File: rtl/chrono_if.sv
// chrono_if: control pulses and display/status outputs of chrono_ctrl.
interface chrono_if;
   import chrono_pkg::*;

   logic  start_stop;
   logic  lap;
   logic  clear;
   disp_t disp;
   logic  running;
   logic  lap_active;
   logic  ovf;

   modport master (
      output start_stop, lap, clear,
      input  disp, running, lap_active, ovf
   );

   modport slave (
      input  start_stop, lap, clear,
      output disp, running, lap_active, ovf
   );
endinterface

// File: rtl/chrono_tick.sv
// chrono_tick: prescaler counting 0..TICK_CYCLES-1 while enabled, one-cycle
// tick on wrap; holds its value while disabled.
module chrono_tick #(
   parameter int unsigned TICK_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   logic [31:0] cnt;

   assign tick = en && (cnt == 32'(TICK_CYCLES - 1));

   // Prescaler counter: clear wins, otherwise advance only when enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 32'd1;
      end
   end
endmodule

// File: rtl/chrono_ctrl.sv
// chrono_ctrl: stopwatch controller with a BCD mm:ss.cc count.
// Defining CHRONO_LAP_EN adds the LAP state and lap-freeze register.
module chrono_ctrl
   import chrono_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 1000000
) (
   input logic     clk,
   input logic     rst,
   chrono_if.slave bus
);
   state_t state;
   state_t state_nx;
   disp_t  count;
   disp_t  count_inc;
   disp_t  disp;
   logic   tick;
   logic   tick_en;
   logic   hit_max;
   logic   running;
   logic   ovf;
`ifdef CHRONO_LAP_EN
   disp_t  lap_reg;
   logic   lap_active;

   assign tick_en = (state == RUN) || (state == LAP);
`else
   logic   unused_lap;

   assign unused_lap = bus.lap;
   assign tick_en    = (state == RUN);
`endif

   assign count_inc = bcd_inc(count);
   assign hit_max   = tick && is_full(count_inc);

   chrono_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_en),
      .clr  (bus.clear),
      .tick (tick)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state: clear > overflow stop > start_stop > lap
   always_comb begin
      state_nx = state;
      if (bus.clear) begin
         state_nx = IDLE;
      end else if (hit_max) begin
         state_nx = PAUSE;
      end else if (bus.start_stop) begin
         case (state)
            IDLE:    state_nx = RUN;
            RUN:     state_nx = PAUSE;
            PAUSE:   if (!ovf) state_nx = RUN;
`ifdef CHRONO_LAP_EN
            LAP:     state_nx = PAUSE;
`endif
            default: state_nx = state;
         endcase
      end
`ifdef CHRONO_LAP_EN
      else if (bus.lap) begin
         if (state == RUN)      state_nx = LAP;
         else if (state == LAP) state_nx = RUN;
      end
`endif
   end

   // Count, sticky overflow and registered display/status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= '0;
         ovf     <= 1'b0;
         disp    <= '0;
         running <= 1'b0;
      end else begin
         if (bus.clear) begin
            count <= '0;
            ovf   <= 1'b0;
         end else if (tick) begin
            count <= count_inc;
            if (hit_max) ovf <= 1'b1;
         end
`ifdef CHRONO_LAP_EN
         disp    <= (state == LAP) ? lap_reg : count;
         running <= (state_nx == RUN) || (state_nx == LAP);
`else
         disp    <= count;
         running <= (state_nx == RUN);
`endif
      end
   end

`ifdef CHRONO_LAP_EN
   // Lap register snapshots the live count on RUN->LAP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lap_reg    <= '0;
         lap_active <= 1'b0;
      end else begin
         if (bus.clear)                           lap_reg <= '0;
         else if (state == RUN && state_nx == LAP) lap_reg <= count;
         lap_active <= (state_nx == LAP);
      end
   end

   assign bus.lap_active = lap_active;
`else
   assign bus.lap_active = 1'b0;
`endif

   assign bus.disp    = disp;
   assign bus.running = running;
   assign bus.ovf     = ovf;
endmodule

// File: tb/tb_chrono_ctrl.sv
// tb_chrono_ctrl: scoreboard bench; dut_a (TICK_CYCLES=4) for the control
// scenarios, dut_b (TICK_CYCLES=2) for the 59:59.99 overflow run.
module tb_chrono_ctrl;
   import chrono_pkg::*;

   typedef struct {
      string       name;
      int unsigned at;
      logic [23:0] disp;
      logic        running;
      logic        lap_active;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned edge_q [2];
   exp_t        q_a[$];
   exp_t        q_b[$];
   bit          done_b = 1'b0;

   chrono_if bus_a ();
   chrono_if bus_b ();

   chrono_ctrl #(.TICK_CYCLES(4)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a.slave)
   );

   chrono_ctrl #(.TICK_CYCLES(2)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Queue an expectation d edges after the last pulse's sampling edge.
   task automatic expect_out(input int which, input string name, input int unsigned d,
                             input logic [23:0] disp, input logic run,
                             input logic lapa, input logic ov);
      exp_t e;
      e.name       = name;
      e.at         = edge_q[which] + d;
      e.disp       = disp;
      e.running    = run;
      e.lap_active = lapa;
      e.ovf        = ov;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
   endtask

   // Called at a negedge; pulse is sampled on the next posedge.
   task automatic pulse(input int which, input logic ss, input logic lp, input logic cl);
      if (which == 0) begin
         bus_a.start_stop = ss;
         bus_a.lap        = lp;
         bus_a.clear      = cl;
      end else begin
         bus_b.start_stop = ss;
         bus_b.lap        = lp;
         bus_b.clear      = cl;
      end
      edge_q[which] = cyc + 1;
   endtask

   task automatic step(input int which, input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         if (which == 0) begin
            bus_a.start_stop = 1'b0;
            bus_a.lap        = 1'b0;
            bus_a.clear      = 1'b0;
         end else begin
            bus_b.start_stop = 1'b0;
            bus_b.lap        = 1'b0;
            bus_b.clear      = 1'b0;
         end
      end
   endtask

   task automatic compare(input exp_t e, input logic [23:0] disp, input logic run,
                          input logic lapa, input logic ov);
      checks++;
      if (disp !== e.disp || run !== e.running || lapa !== e.lap_active || ov !== e.ovf) begin
         errors++;
         $display("FAIL %s cyc=%0d: got disp=%h running=%b lap_active=%b ovf=%b, want disp=%h running=%b lap_active=%b ovf=%b",
                  e.name, cyc, disp, run, lapa, ov, e.disp, e.running, e.lap_active, e.ovf);
      end
   endtask

   // Monitor: pop and compare every expectation that has come due
   always @(negedge clk) begin
      while (q_a.size() > 0 && q_a[0].at <= cyc)
         compare(q_a.pop_front(), bus_a.disp, bus_a.running, bus_a.lap_active, bus_a.ovf);
      while (q_b.size() > 0 && q_b[0].at <= cyc)
         compare(q_b.pop_front(), bus_b.disp, bus_b.running, bus_b.lap_active, bus_b.ovf);
   end

   initial begin : stim_a
      rst_a            = 1'b0;
      bus_a.start_stop = 1'b0;
      bus_a.lap        = 1'b0;
      bus_a.clear      = 1'b0;
      @(negedge clk);
      edge_q[0] = cyc;
      expect_out(0, "reset_state", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 3);
      rst_a = 1'b1;
      step(0, 2);

      // Run to 1.00 s and the cs->sec carry, then pause and clear
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "start_running", 0, 24'h000000, 1'b1, 1'b0, 1'b0);
      expect_out(0, "first_tick_pre", 4, 24'h000000, 1'b1, 1'b0, 1'b0);
      expect_out(0, "first_tick", 5, 24'h000001, 1'b1, 1'b0, 1'b0);
      expect_out(0, "cs_carry_pre", 400, 24'h000099, 1'b1, 1'b0, 1'b0);
      expect_out(0, "cs_carry", 401, 24'h000100, 1'b1, 1'b0, 1'b0);
      step(0, 403);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "pause_enter", 0, 24'h000100, 1'b0, 1'b0, 1'b0);
      expect_out(0, "pause_hold", 20, 24'h000100, 1'b0, 1'b0, 1'b0);
      step(0, 22);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_after_pause", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);

      // Prescaler holds its phase across a pause
      pulse(0, 1'b1, 1'b0, 1'b0);
      step(0, 10);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "pause_mid", 0, 24'h000002, 1'b0, 1'b0, 1'b0);
      expect_out(0, "pause_held", 40, 24'h000002, 1'b0, 1'b0, 1'b0);
      step(0, 50);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "resume_run", 0, 24'h000002, 1'b1, 1'b0, 1'b0);
      expect_out(0, "resume_hold", 2, 24'h000002, 1'b1, 1'b0, 1'b0);
      expect_out(0, "resume_tick", 3, 24'h000003, 1'b1, 1'b0, 1'b0);
      step(0, 5);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_after_resume", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);

      // clear and start_stop together: clear wins, start_stop dropped
      pulse(0, 1'b1, 1'b0, 1'b0);
      step(0, 30);
      pulse(0, 1'b1, 1'b0, 1'b1);
      expect_out(0, "clr_ss_edge", 0, 24'h000007, 1'b0, 1'b0, 1'b0);
      expect_out(0, "clr_ss_zero", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      expect_out(0, "clr_ss_idle", 10, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 12);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "restart_pre", 4, 24'h000000, 1'b1, 1'b0, 1'b0);
      expect_out(0, "restart_tick", 5, 24'h000001, 1'b1, 1'b0, 1'b0);
      step(0, 8);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_after_restart", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);

`ifdef CHRONO_LAP_EN
      // Lap freeze, unfreeze, then LAP->PAUSE shows the live count
      pulse(0, 1'b1, 1'b0, 1'b0);
      step(0, 201);
      pulse(0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "lap_enter", 0, 24'h000050, 1'b1, 1'b1, 1'b0);
      expect_out(0, "lap_frozen", 50, 24'h000050, 1'b1, 1'b1, 1'b0);
      expect_out(0, "lap_frozen_end", 99, 24'h000050, 1'b1, 1'b1, 1'b0);
      step(0, 100);
      pulse(0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "lap_exit_edge", 0, 24'h000050, 1'b1, 1'b0, 1'b0);
      expect_out(0, "lap_exit_live", 1, 24'h000075, 1'b1, 1'b0, 1'b0);
      step(0, 10);
      pulse(0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "lap2_enter", 0, 24'h000077, 1'b1, 1'b1, 1'b0);
      step(0, 20);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "lap_to_pause", 0, 24'h000077, 1'b0, 1'b0, 1'b0);
      expect_out(0, "pause_live", 1, 24'h000082, 1'b0, 1'b0, 1'b0);
      expect_out(0, "pause_live_hold", 5, 24'h000082, 1'b0, 1'b0, 1'b0);
      step(0, 7);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_after_lap", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);
`else
      // lap pulses have no effect without the lap feature
      pulse(0, 1'b1, 1'b0, 1'b0);
      step(0, 21);
      pulse(0, 1'b0, 1'b1, 1'b0);
      expect_out(0, "lap_ignored", 0, 24'h000005, 1'b1, 1'b0, 1'b0);
      expect_out(0, "lap_ignored_live", 20, 24'h000010, 1'b1, 1'b0, 1'b0);
      step(0, 22);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_after_lap", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);
`endif

      // Asynchronous reset mid-RUN, then a fresh start from zero
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "run_before_reset", 0, 24'h000000, 1'b1, 1'b0, 1'b0);
      step(0, 150);
      expect_out(0, "pre_reset", 150, 24'h000037, 1'b1, 1'b0, 1'b0);
      step(0, 1);
      @(posedge clk);
      #2;
      rst_a     = 1'b0;
      edge_q[0] = cyc;
      expect_out(0, "reset_async", 0, 24'h000000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_a = 1'b1;
      @(negedge clk);
      edge_q[0] = cyc;
      expect_out(0, "reset_idle", 5, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 6);
      pulse(0, 1'b1, 1'b0, 1'b0);
      expect_out(0, "post_reset_pre", 4, 24'h000000, 1'b1, 1'b0, 1'b0);
      expect_out(0, "post_reset_tick", 5, 24'h000001, 1'b1, 1'b0, 1'b0);
      step(0, 8);
      pulse(0, 1'b0, 1'b0, 1'b1);
      expect_out(0, "clear_final", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(0, 4);

      for (int unsigned g = 0; g < 800000 && !done_b; g++) @(negedge clk);
      if (!done_b) begin
         checks++;
         errors++;
         $display("FAIL ovf_timeout: overflow scenario still running, want done");
      end
      step(0, 2);
      checks++;
      if (q_a.size() + q_b.size() != 0) begin
         errors++;
         $display("FAIL pending_checks: %0d left, want 0", q_a.size() + q_b.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim_b
      rst_b            = 1'b0;
      bus_b.start_stop = 1'b0;
      bus_b.lap        = 1'b0;
      bus_b.clear      = 1'b0;
      @(negedge clk);
      step(1, 3);
      rst_b = 1'b1;
      step(1, 2);

      // 359999 ticks of 2 cycles reach 59:59.99
      pulse(1, 1'b1, 1'b0, 1'b0);
      expect_out(1, "ovf_before", 719997, 24'h595998, 1'b1, 1'b0, 1'b0);
      expect_out(1, "ovf_hit", 719998, 24'h595998, 1'b0, 1'b0, 1'b1);
      expect_out(1, "ovf_disp", 719999, 24'h595999, 1'b0, 1'b0, 1'b1);
      step(1, 720005);
      pulse(1, 1'b1, 1'b0, 1'b0);
      expect_out(1, "ovf_ss_ignored", 0, 24'h595999, 1'b0, 1'b0, 1'b1);
      expect_out(1, "ovf_ss_hold", 10, 24'h595999, 1'b0, 1'b0, 1'b1);
      step(1, 12);
      pulse(1, 1'b0, 1'b0, 1'b1);
      expect_out(1, "ovf_clear_edge", 0, 24'h595999, 1'b0, 1'b0, 1'b0);
      expect_out(1, "ovf_clear_zero", 1, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(1, 4);
      done_b = 1'b1;
   end
endmodule
